cpu_run_ctrl: RTL and testbench

Host-side run/step controller that drives the CPU enable generator's ALWAYS_CPU_EN and ONCE_CPU_EN inputs.
- Accepts halt, run, step-N and run-to-breakpoint commands over a valid/ready handshake.
- Sequences the enable levels so that each step produces exactly one rising edge on ONCE_CPU_EN.
- Reports busy/done status, halt reason and enabled-cycle count to the debug front panel.

---
 rtl/cpu_run_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Host-side run/step controller for the CPU enable generator. It accepts
// halt / run / step-N / run-to-break commands and drives the ALWAYS and ONCE
// enable levels. Each step is one ONCE pulse: STEP_HI cycles high, then
// STEP_LO cycles low. It also reports busy/done status, the halt reason and
// a saturating count of enabled CPU cycles.
//
// Optional feature: define CPU_RUN_CTRL_BREAKPOINT_EN to build the BRKRUN
// state and the PC/breakpoint compare. Without it, op 11 behaves as run,
// and i_pc / i_brk_addr are ignored.
//
// Ports:
//   i_clk, i_rst_n    clock, synchronous active-low reset
//   i_cmd_valid/op/arg, o_cmd_ready   command channel
//   i_pc, i_brk_addr  program counter and breakpoint address
//   i_cpu_en_in       CPU_EN_OUT fed back from the enable generator
//   i_cnt_clr         synchronous clear of o_cycle_cnt
//   o_always_cpu_en, o_once_cpu_en   enable levels (registered)
//   o_busy, o_done, o_halt_reason    status (registered)
//   o_cycle_cnt       enabled-cycle counter (registered, saturating)
//   o_dbg_state       current FSM state, for debug visibility
//
// Handshake: a command transfers on a posedge where i_cmd_valid and
// o_cmd_ready are both 1. o_cmd_ready is combinational: it is 1 in IDLE,
// and 1 in any state when the presented op is halt. The host holds the
// command stable until it transfers.

module cpu_run_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int STEP_HI = 2,
  parameter int STEP_LO = 2,
  parameter int CNT_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd_op,
  input  logic [15:0]       i_cmd_arg,
  output logic              o_cmd_ready,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_brk_addr,
  input  logic              i_cpu_en_in,
  input  logic              i_cnt_clr,
  output logic              o_always_cpu_en,
  output logic              o_once_cpu_en,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_halt_reason,
  output logic [CNT_W-1:0]  o_cycle_cnt,
  output logic [2:0]        o_dbg_state
);

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_BRK  = 2'b11;

  localparam logic [1:0] HR_NONE = 2'd0;
  localparam logic [1:0] HR_HOST = 2'd1;
  localparam logic [1:0] HR_STEP = 2'd2;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  localparam logic [1:0] HR_BRK  = 2'd3;
`endif

  // Phase counter is shared by STEP_HI and STEP_LO; sized for the longer one.
  localparam int PH_MAX = (STEP_HI > STEP_LO) ? STEP_HI : STEP_LO;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    S_BRKRUN  = 3'd2,
`endif
    S_STEP_HI = 3'd3,
    S_STEP_LO = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PH_W-1:0]   r_phase;
  logic [PH_W-1:0]   w_phase_nxt;
  logic [15:0]       r_remain;
  logic [15:0]       w_remain_nxt;
  logic              w_done_nxt;
  logic [1:0]        w_hr_nxt;
  logic              w_accept;
  logic              w_brk_hit;

  assign o_cmd_ready = (r_state == S_IDLE) | (i_cmd_op == OP_HALT);
  assign w_accept    = i_cmd_valid & o_cmd_ready;
  assign o_dbg_state = r_state;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  assign w_brk_hit = i_cpu_en_in & (i_pc == i_brk_addr);
`else
  logic w_unused_brk;
  assign w_brk_hit    = 1'b0;
  assign w_unused_brk = ^{i_pc, i_brk_addr};
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_remain_nxt = r_remain;
    w_done_nxt   = 1'b0;
    w_hr_nxt     = o_halt_reason;

    if (w_accept && (i_cmd_op == OP_HALT)) begin
      // Halt wins over anything the current state would do this cycle.
      w_state_nxt  = S_IDLE;
      w_phase_nxt  = '0;
      w_remain_nxt = '0;
      w_done_nxt   = 1'b1;
      w_hr_nxt     = HR_HOST;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (i_cmd_op)
              OP_RUN: begin
                w_state_nxt = S_RUN;
                w_hr_nxt    = HR_NONE;
              end
              OP_STEP: begin
                if (i_cmd_arg == 16'd0) begin
                  w_done_nxt = 1'b1;
                  w_hr_nxt   = HR_STEP;
                end else begin
                  w_state_nxt  = S_STEP_HI;
                  w_remain_nxt = i_cmd_arg;
                  w_phase_nxt  = '0;
                  w_hr_nxt     = HR_NONE;
                end
              end
              OP_BRK: begin
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
                w_state_nxt = S_BRKRUN;
`else
                w_state_nxt = S_RUN;
`endif
                w_hr_nxt    = HR_NONE;
              end
              default: ;
            endcase
          end
        end
        S_RUN: ;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        S_BRKRUN: begin
          if (w_brk_hit) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_hr_nxt    = HR_BRK;
          end
        end
`endif
        S_STEP_HI: begin
          if (r_phase == PH_W'(STEP_HI - 1)) begin
            w_state_nxt = S_STEP_LO;
            w_phase_nxt = '0;
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
          end
        end
        S_STEP_LO: begin
          if (r_phase == PH_W'(STEP_LO - 1)) begin
            w_phase_nxt  = '0;
            w_remain_nxt = r_remain - 16'd1;
            if (r_remain == 16'd1) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
              w_hr_nxt    = HR_STEP;
            end else begin
              w_state_nxt = S_STEP_HI;
            end
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state
  // register: an accept at posedge T shows the new levels right after T.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_phase         <= '0;
      r_remain        <= '0;
      o_always_cpu_en <= 1'b0;
      o_once_cpu_en   <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_halt_reason   <= HR_NONE;
    end else begin
      r_state         <= w_state_nxt;
      r_phase         <= w_phase_nxt;
      r_remain        <= w_remain_nxt;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
      o_always_cpu_en <= (w_state_nxt == S_RUN) || (w_state_nxt == S_BRKRUN);
`else
      o_always_cpu_en <= (w_state_nxt == S_RUN);
`endif
      o_once_cpu_en   <= (w_state_nxt == S_STEP_HI);
      o_busy          <= (w_state_nxt != S_IDLE);
      o_done          <= w_done_nxt;
      o_halt_reason   <= w_hr_nxt;
    end
  end

  // Clear beats increment; the count sticks at all ones.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_cycle_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_cycle_cnt <= '0;
    end else if (i_cpu_en_in && (o_cycle_cnt != '1)) begin
      o_cycle_cnt <= o_cycle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl. Directed commands are issued by driver tasks;
// each command that must finish with a DONE pulse pushes {cycle, reason}
// into exp_q, and a monitor branch pops and compares on every DONE pulse.
// The enable generator is modelled as CPU_EN_IN = ALWAYS | ONCE, and the PC
// advances by 4 on every enabled cycle. CNT_W is reduced to 8 so that
// saturation can be reached.

module tb_cpu_run_ctrl;

  localparam int ADDR_W  = 16;
  localparam int STEP_HI = 2;
  localparam int STEP_LO = 2;
  localparam int CNT_W   = 8;
  localparam int PER     = STEP_HI + STEP_LO;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n     = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op    = 2'b00;
  logic [15:0]       cmd_arg   = 16'd0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] brk_addr  = 16'h0040;
  logic              cnt_clr   = 1'b0;
  logic              cpu_en;
  logic              always_en, once_en, busy, done;
  logic [1:0]        halt_reason;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [2:0]        dbg_state;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ADDR_W-1:0] pc      = 16'h0000;
  logic [ADDR_W-1:0] pc_init = 16'h0000;
  logic              pc_load = 1'b0;
  always @(posedge clk) begin
    if (pc_load)     pc <= pc_init;
    else if (cpu_en) pc <= pc + 16'd4;
  end

  assign cpu_en = always_en | once_en;

  cpu_run_ctrl #(
    .ADDR_W(ADDR_W), .STEP_HI(STEP_HI), .STEP_LO(STEP_LO), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid),
    .i_cmd_op(cmd_op),
    .i_cmd_arg(cmd_arg),
    .o_cmd_ready(cmd_ready),
    .i_pc(pc),
    .i_brk_addr(brk_addr),
    .i_cpu_en_in(cpu_en),
    .i_cnt_clr(cnt_clr),
    .o_always_cpu_en(always_en),
    .o_once_cpu_en(once_en),
    .o_busy(busy),
    .o_done(done),
    .o_halt_reason(halt_reason),
    .o_cycle_cnt(cycle_cnt),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  bit stim_done = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // ---------------- drivers ----------------
  // Presents a command and waits (bounded) for it to transfer. When push is
  // set, the expected DONE {cycle, reason} is queued before the transfer
  // edge. Returns k = the cycle index of the transfer edge, at the negedge
  // right after it.
  task automatic send_cmd(input logic [1:0] op, input logic [15:0] arg,
                          input bit push, input logic [1:0] hr, input int dly,
                          output int k);
    bit ok;
    ok = 1'b0;
    k  = -1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (cmd_ready) begin
        ok = 1'b1;
        k  = cyc + 1;
        if (push) exp_q.push_back({32'(k + dly), hr});
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    if (!ok) check("cmd_accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic set_pc(input logic [ADDR_W-1:0] v);
    @(negedge clk);
    pc_init = v;
    pc_load = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  // ---------------- main ----------------
  initial begin
    int k, h, n_rdy;
    logic [15:0] once_bits, busy_bits;
    logic        seen;
    logic [33:0] e;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_ctrl", {25'd0, always_en, once_en, busy, done, halt_reason, cmd_ready}, 32'h01);
    check("reset_cnt", 32'(cycle_cnt), 32'd0);

    fork
      begin : stimulus
        // halt while idle: no-op with DONE, reason host
        send_cmd(2'b00, 16'd0, 1'b1, 2'd1, 0, k);
        repeat (2) @(negedge clk);
        check("hr_hold", 32'(halt_reason), 32'd1);

        // step-0: immediate DONE, reason steps exhausted, never busy
        send_cmd(2'b10, 16'd0, 1'b1, 2'd2, 0, k);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
          seen = seen | busy | once_en;
          @(negedge clk);
        end
        check("step0_quiet", {31'd0, seen}, 32'd0);

        // step-3: ONCE pattern and DONE after 3 periods
        send_cmd(2'b10, 16'd3, 1'b1, 2'd2, 3 * PER, k);
        check("step3_hr_clear", 32'(halt_reason), 32'd0);
        once_bits = '0;
        busy_bits = '0;
        for (int i = 0; i < 16; i++) begin
          once_bits[i] = once_en;
          busy_bits[i] = busy;
          @(negedge clk);
        end
        check("step3_once_pattern", 32'(once_bits), 32'h0333);
        check("step3_busy_pattern", 32'(busy_bits), 32'h0FFF);

        // run, halt 10 cycles later: 10 enabled cycles counted
        pulse_clr();
        check("clr_idle", 32'(cycle_cnt), 32'd0);
        send_cmd(2'b01, 16'd0, 1'b0, 2'd0, 0, k);
        check("run_hr_clear", 32'(halt_reason), 32'd0);
        check("run_always_on", {31'd0, always_en}, 32'd1);
        repeat (8) @(negedge clk);
        send_cmd(2'b00, 16'd0, 1'b1, 2'd1, 0, h);
        check("halt_levels_off", {30'd0, always_en, busy}, 32'd0);
        check("run_cnt", 32'(cycle_cnt), 32'd10);

        // non-halt command held during RUN waits
        send_cmd(2'b01, 16'd0, 1'b0, 2'd0, 0, k);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_arg   = 16'd1;
        n_rdy     = 0;
        for (int i = 0; i < 6; i++) begin
          #1;
          if (cmd_ready) n_rdy++;
          @(negedge clk);
        end
        check("busy_ready_low", 32'(n_rdy), 32'd0);
        check("still_running", {30'd0, always_en, once_en}, 32'd2);
        cmd_valid = 1'b0;
        send_cmd(2'b00, 16'd0, 1'b1, 2'd1, 0, k);
        send_cmd(2'b10, 16'd1, 1'b1, 2'd2, PER, k);
        repeat (PER + 2) @(negedge clk);

        // clear and increment on the same edge gives 0
        send_cmd(2'b01, 16'd0, 1'b0, 2'd0, 0, k);
        repeat (3) @(negedge clk);
        pulse_clr();
        check("clr_beats_inc", 32'(cycle_cnt), 32'd0);
        send_cmd(2'b00, 16'd0, 1'b1, 2'd1, 0, k);

        // saturation
        pulse_clr();
        send_cmd(2'b01, 16'd0, 1'b0, 2'd0, 0, k);
        repeat (300) @(negedge clk);
        check("cnt_saturate", 32'(cycle_cnt), 32'd255);
        send_cmd(2'b00, 16'd0, 1'b1, 2'd1, 0, k);

        // run-to-break from PC 0x38 toward breakpoint 0x40
        set_pc(16'h0038);
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        send_cmd(2'b11, 16'd0, 1'b1, 2'd3, 3, k);
        repeat (6) @(negedge clk);
        check("brk_pc_stop", 32'(pc), 32'h0044);
        check("brk_levels_off", {30'd0, always_en, busy}, 32'd0);
        // halt transferring on the very edge of the match
        set_pc(16'h0038);
        send_cmd(2'b11, 16'd0, 1'b0, 2'd0, 0, k);
        @(negedge clk);
        send_cmd(2'b00, 16'd0, 1'b1, 2'd1, 0, h);
        check("halt_on_match_edge", 32'(h - k), 32'd3);
        repeat (5) @(negedge clk);
`else
        send_cmd(2'b11, 16'd0, 1'b0, 2'd0, 0, k);
        repeat (20) @(negedge clk);
        check("nobrk_still_running", {30'd0, always_en, busy}, 32'd3);
        send_cmd(2'b00, 16'd0, 1'b1, 2'd1, 0, k);
        repeat (3) @(negedge clk);
`endif

        // reset mid-run: aborts with no DONE
        send_cmd(2'b01, 16'd0, 1'b0, 2'd0, 0, k);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrun_reset_ctrl", {25'd0, always_en, once_en, busy, done, halt_reason, cmd_ready}, 32'h01);
        check("midrun_reset_cnt", 32'(cycle_cnt), 32'd0);
        repeat (4) @(negedge clk);
        stim_done = 1'b1;
      end

      begin : monitor
        while (!stim_done) begin
          @(negedge clk);
          if (done) begin
            if (exp_q.size() == 0) begin
              check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("done_reason", 32'(halt_reason), 32'(e[1:0]));
              check("done_cycle", 32'(cyc), e[33:2]);
            end
          end
        end
      end

      begin : watchdog
        for (int i = 0; i < 20000 && !stim_done; i++) @(posedge clk);
        if (!stim_done) begin
          n_chk++;
          $display("FAIL watchdog: stimulus still running at cycle %0d, required to finish", cyc);
          $display("%0d/%0d checks passed", n_pass, n_chk);
          $fatal(1, "watchdog expired");
        end
      end
    join

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
